rs_param: RTL and testbench

- Parametrised reservation station for the out-of-order core; next generation of the 3-wide RS.
- Sits between dispatch and the FU issue stage.
- Holds up to RS_DEPTH renamed instructions. Wakes source operands from CDB tag broadcasts.
- Issues up to ISSUE_W ready instructions per cycle to free FU classes, with a squash path for mispredict recovery.

---
 rtl/rs_pkg.sv | 26 ++
 rtl/rs_psel.sv | 31 +++
 rtl/rs_param.sv | 206 ++++++++++++++++++++
 tb/tb_rs_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// rs_pkg: shared reservation-station types; the entry layout fixes the tag, FU-class and payload widths.
package rs_pkg;

  localparam int RS_PR_W      = 6;
  localparam int RS_PAYLOAD_W = 96;
  localparam int RS_NUM_FU    = 4;
  localparam int RS_FU_W      = 2;

  typedef enum logic [RS_FU_W-1:0] {
    FU_ALU  = 2'd0,
    FU_LS   = 2'd1,
    FU_MULT = 2'd2,
    FU_BR   = 2'd3
  } fu_e;

  typedef struct packed {
    logic                    valid;
    logic [RS_PR_W-1:0]      src1_pr;
    logic [RS_PR_W-1:0]      src2_pr;
    logic                    src1_rdy;
    logic                    src2_rdy;
    fu_e                     fu;
    logic [RS_PAYLOAD_W-1:0] payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_psel.sv
// rs_psel: combinational N-request / M-grant priority selector; grant m is the (m+1)-th request in scan order.
// REQ_UP=1 scans from index 0 upward, REQ_UP=0 from the top index downward.
module rs_psel #(
  parameter int N      = 16,
  parameter int M      = 3,
  parameter bit REQ_UP = 1'b1,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]         req,
  output logic [M-1:0]         gnt_vld,
  output logic [M-1:0][IW-1:0] gnt_idx
);

  logic [N-1:0] rem;

  always_comb begin
    rem     = req;
    gnt_vld = '0;
    gnt_idx = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        if (!gnt_vld[m] && rem[REQ_UP ? n : N-1-n]) begin
          gnt_vld[m] = 1'b1;
          gnt_idx[m] = IW'(REQ_UP ? n : N-1-n);
        end
      end
      if (gnt_vld[m]) rem[gnt_idx[m]] = 1'b0;
    end
  end

endmodule

// File: rtl/rs_param.sv
// rs_param: reservation station; dispatch lands at the edge, issue is picked combinationally from registered state.
// Stall depends only on the registered free count; RS_AGE_ORDER_EN selects oldest-first issue (default: lowest index first).
module rs_param
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = 16,
  parameter int DISP_W    = 3,
  parameter int ISSUE_W   = 3,
  parameter int CDB_W     = 3,
  parameter int PR_W      = RS_PR_W,
  parameter int NUM_FU    = RS_NUM_FU,
  parameter int PAYLOAD_W = RS_PAYLOAD_W,
  localparam int FU_W     = $clog2(NUM_FU),
  localparam int IDX_W    = $clog2(RS_DEPTH),
  localparam int OCC_W    = IDX_W + 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [DISP_W-1:0]                   disp_valid,
  input  logic [DISP_W-1:0][PR_W-1:0]         disp_src1_pr,
  input  logic [DISP_W-1:0][PR_W-1:0]         disp_src2_pr,
  input  logic [DISP_W-1:0]                   disp_src1_rdy,
  input  logic [DISP_W-1:0]                   disp_src2_rdy,
  input  logic [DISP_W-1:0][FU_W-1:0]         disp_fu,
  input  logic [DISP_W-1:0][PAYLOAD_W-1:0]    disp_payload,
  output logic [DISP_W-1:0]                   struct_stall,
  input  logic [CDB_W-1:0]                    cdb_valid,
  input  logic [CDB_W-1:0][PR_W-1:0]          cdb_tag,
  input  logic [NUM_FU-1:0]                   fu_ready,
  output logic [ISSUE_W-1:0]                  issue_valid,
  output logic [ISSUE_W-1:0][FU_W-1:0]        issue_fu,
  output logic [ISSUE_W-1:0][PR_W-1:0]        issue_src1_pr,
  output logic [ISSUE_W-1:0][PR_W-1:0]        issue_src2_pr,
  output logic [ISSUE_W-1:0][PAYLOAD_W-1:0]   issue_payload,
  input  logic                                squash,
  output logic [OCC_W-1:0]                    occupancy
);

  rs_entry_t [RS_DEPTH-1:0]        ent_q, ent_d;
  logic [OCC_W-1:0]                occ_q, occ_d;
  logic [RS_DEPTH-1:0]             free_vec, elig, issued, win_mask;
  logic [NUM_FU-1:0][RS_DEPTH-1:0] elig_cls;
  logic [DISP_W-1:0]               acc, alloc_vld;
  logic [DISP_W-1:0][IDX_W-1:0]    alloc_idx;
  logic [ISSUE_W-1:0]              sel_vld;
  logic [ISSUE_W-1:0][IDX_W-1:0]   sel_idx;

  function automatic logic cdb_hit(input logic [PR_W-1:0] tag,
                                   input logic [CDB_W-1:0] vld,
                                   input logic [CDB_W-1:0][PR_W-1:0] tags);
    cdb_hit = 1'b0;
    for (int c = 0; c < CDB_W; c++) if (vld[c] && tags[c] == tag) cdb_hit = 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      free_vec[i] = !ent_q[i].valid;
      elig[i]     = ent_q[i].valid && ent_q[i].src1_rdy && ent_q[i].src2_rdy && fu_ready[ent_q[i].fu];
    end
    for (int c = 0; c < NUM_FU; c++)
      for (int i = 0; i < RS_DEPTH; i++)
        elig_cls[c][i] = elig[i] && (ent_q[i].fu == fu_e'(c[FU_W-1:0]));
  end

  // Grant k exists iff at least k+1 entries are free, so it doubles as the stall term.
  rs_psel #(.N(RS_DEPTH), .M(DISP_W), .REQ_UP(1'b1)) u_alloc (
    .req     (free_vec),
    .gnt_vld (alloc_vld),
    .gnt_idx (alloc_idx)
  );

  assign struct_stall = ~alloc_vld;
  assign acc          = disp_valid & alloc_vld & {DISP_W{!squash}};

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] = 1 means entry j is older than entry i.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  logic [RS_DEPTH-1:0]               rem_mask, pick, alloc_so_far;

  function automatic logic [RS_DEPTH-1:0] oldest_oh(input logic [RS_DEPTH-1:0] mask,
                                                    input logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age);
    oldest_oh = '0;
    for (int i = 0; i < RS_DEPTH; i++)
      if (mask[i] && ((age[i] & mask) == '0)) oldest_oh[i] = 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] oh2idx(input logic [RS_DEPTH-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) if (oh[i]) oh2idx = IDX_W'(i);
  endfunction

  always_comb begin
    win_mask = '0;
    for (int c = 0; c < NUM_FU; c++) win_mask = win_mask | oldest_oh(elig_cls[c], age_q);
    rem_mask = win_mask;
    pick     = '0;
    sel_vld  = '0;
    sel_idx  = '0;
    for (int m = 0; m < ISSUE_W; m++) begin
      pick       = oldest_oh(rem_mask, age_q);
      sel_vld[m] = |pick;
      sel_idx[m] = oh2idx(pick);
      rem_mask   = rem_mask & ~pick;
    end
  end

  always_comb begin
    age_d        = age_q;
    alloc_so_far = '0;
    for (int k = 0; k < DISP_W; k++) begin
      if (acc[k]) begin
        for (int j = 0; j < RS_DEPTH; j++) age_d[j][alloc_idx[k]] = 1'b0;
        age_d[alloc_idx[k]]          = ~free_vec | alloc_so_far;
        alloc_so_far[alloc_idx[k]]   = 1'b1;
      end
    end
    if (squash) age_d = '0;
  end
`else
  logic [NUM_FU-1:0][RS_DEPTH-1:0] cls_win;

  for (genvar c = 0; c < NUM_FU; c++) begin : g_cls
    logic [0:0]            w_vld;
    logic [0:0][IDX_W-1:0] w_idx;
    rs_psel #(.N(RS_DEPTH), .M(1), .REQ_UP(1'b1)) u_cls (
      .req     (elig_cls[c]),
      .gnt_vld (w_vld),
      .gnt_idx (w_idx)
    );
    assign cls_win[c] = w_vld[0] ? (RS_DEPTH'(1) << w_idx[0]) : '0;
  end

  always_comb begin
    win_mask = '0;
    for (int c = 0; c < NUM_FU; c++) win_mask = win_mask | cls_win[c];
  end

  // Class winners are disjoint by class, so ordering them by index fills the slots.
  rs_psel #(.N(RS_DEPTH), .M(ISSUE_W), .REQ_UP(1'b1)) u_issue (
    .req     (win_mask),
    .gnt_vld (sel_vld),
    .gnt_idx (sel_idx)
  );
`endif

  always_comb begin
    issued = '0;
    for (int m = 0; m < ISSUE_W; m++) begin
      issue_valid[m]   = sel_vld[m] && !squash;
      issue_fu[m]      = ent_q[sel_idx[m]].fu;
      issue_src1_pr[m] = ent_q[sel_idx[m]].src1_pr;
      issue_src2_pr[m] = ent_q[sel_idx[m]].src2_pr;
      issue_payload[m] = ent_q[sel_idx[m]].payload;
      if (issue_valid[m]) issued[sel_idx[m]] = 1'b1;
    end
  end

  always_comb begin
    ent_d = ent_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].valid) begin
        if (cdb_hit(ent_q[i].src1_pr, cdb_valid, cdb_tag)) ent_d[i].src1_rdy = 1'b1;
        if (cdb_hit(ent_q[i].src2_pr, cdb_valid, cdb_tag)) ent_d[i].src2_rdy = 1'b1;
        if (issued[i]) ent_d[i].valid = 1'b0;
      end
    end
    for (int k = 0; k < DISP_W; k++) begin
      if (acc[k]) begin
        ent_d[alloc_idx[k]] = '{
          valid:    1'b1,
          src1_pr:  disp_src1_pr[k],
          src2_pr:  disp_src2_pr[k],
          src1_rdy: disp_src1_rdy[k] || (disp_src1_pr[k] == '0) ||
                    cdb_hit(disp_src1_pr[k], cdb_valid, cdb_tag),
          src2_rdy: disp_src2_rdy[k] || (disp_src2_pr[k] == '0) ||
                    cdb_hit(disp_src2_pr[k], cdb_valid, cdb_tag),
          fu:       fu_e'(disp_fu[k]),
          payload:  disp_payload[k]
        };
      end
    end
    if (squash)
      for (int i = 0; i < RS_DEPTH; i++) ent_d[i].valid = 1'b0;
    occ_d = '0;
    for (int i = 0; i < RS_DEPTH; i++) occ_d = occ_d + OCC_W'(ent_d[i].valid);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      occ_q <= '0;
`ifdef RS_AGE_ORDER_EN
      age_q <= '0;
`endif
    end else begin
      ent_q <= ent_d;
      occ_q <= occ_d;
`ifdef RS_AGE_ORDER_EN
      age_q <= age_d;
`endif
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_rs_param.sv
// tb_rs_param: directed checks of rs_param reset, fill/stall, wakeup, class contention, zero tag and squash.
module tb_rs_param;
  import rs_pkg::*;

  logic                clock = 1'b0;
  logic                reset;
  logic [2:0]          disp_valid;
  logic [2:0][5:0]     disp_src1_pr, disp_src2_pr;
  logic [2:0]          disp_src1_rdy, disp_src2_rdy;
  logic [2:0][1:0]     disp_fu;
  logic [2:0][95:0]    disp_payload;
  logic [2:0]          struct_stall;
  logic [2:0]          cdb_valid;
  logic [2:0][5:0]     cdb_tag;
  logic [3:0]          fu_ready;
  logic [2:0]          issue_valid;
  logic [2:0][1:0]     issue_fu;
  logic [2:0][5:0]     issue_src1_pr, issue_src2_pr;
  logic [2:0][95:0]    issue_payload;
  logic                squash;
  logic [4:0]          occupancy;

  int n_chk = 0;
  int n_err = 0;
  int exp_ord [3];

  always #5 clock = ~clock;

  rs_param dut (
    .clock(clock), .reset(reset),
    .disp_valid(disp_valid), .disp_src1_pr(disp_src1_pr), .disp_src2_pr(disp_src2_pr),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy), .disp_fu(disp_fu),
    .disp_payload(disp_payload), .struct_stall(struct_stall),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .fu_ready(fu_ready),
    .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_src1_pr(issue_src1_pr),
    .issue_src2_pr(issue_src2_pr), .issue_payload(issue_payload),
    .squash(squash), .occupancy(occupancy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic idle();
    disp_valid = '0;
    cdb_valid  = '0;
    squash     = 1'b0;
  endtask

  task automatic put(input int k, input logic [5:0] s1, input logic r1,
                     input logic [5:0] s2, input logic r2, input logic [1:0] fu, input int id);
    disp_valid[k]    = 1'b1;
    disp_src1_pr[k]  = s1;
    disp_src1_rdy[k] = r1;
    disp_src2_pr[k]  = s2;
    disp_src2_rdy[k] = r2;
    disp_fu[k]       = fu;
    disp_payload[k]  = 96'(id);
  endtask

  task automatic bcast(input int c, input logic [5:0] t);
    cdb_valid[c] = 1'b1;
    cdb_tag[c]   = t;
  endtask

  initial begin
`ifdef RS_AGE_ORDER_EN
    exp_ord = '{500, 501, 502};
`else
    exp_ord = '{501, 500, 502};
`endif
    reset = 1'b0;
    fu_ready = '0;
    disp_src1_pr = '0; disp_src2_pr = '0; disp_src1_rdy = '0; disp_src2_rdy = '0;
    disp_fu = '0; disp_payload = '0; cdb_tag = '0;
    idle();
    #3;
    check("rst_occ", occupancy, 0);
    check("rst_iv", issue_valid, 0);
    check("rst_stall", struct_stall, 0);
    #9 reset = 1'b1;

    // Async reset in the middle of traffic
    put(0, 50, 1, 51, 1, FU_ALU, 1); put(1, 50, 0, 51, 0, FU_ALU, 2); put(2, 50, 0, 51, 0, FU_ALU, 3);
    nxt(); idle();
    put(0, 50, 0, 51, 0, FU_ALU, 4); put(1, 50, 0, 51, 0, FU_ALU, 5);
    nxt(); idle();
    smp();
    check("pre_rst_occ", occupancy, 5);
    fu_ready = 4'hf;
    #1 check("pre_rst_iv", issue_valid, 3'b001);
    reset = 1'b0;
    #1;
    check("async_occ", occupancy, 0);
    check("async_iv", issue_valid, 0);
    check("async_stall", struct_stall, 0);
    #1 reset = 1'b1;
    fu_ready = '0;

    // Fill to full
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) put(k, 50, 0, 51, 0, FU_ALU, 100 + 3*i + k);
      nxt(); smp();
      check("fill_occ", occupancy, 5'(3*(i+1)));
    end
    check("stall_f1", struct_stall, 3'b110);
    nxt(); idle(); smp();
    check("full_occ", occupancy, 16);
    check("full_stall", struct_stall, 3'b111);
    check("full_iv", issue_valid, 0);
    bcast(0, 50); bcast(1, 51);
    nxt(); idle(); fu_ready = 4'b0001; smp();
    check("cls_iv0", issue_valid, 3'b001);
    check("cls_pl0", issue_payload[0], 100);
    check("cls_s2", issue_src2_pr[0], 51);
    nxt(); smp();
    check("iss_occ", occupancy, 15);
    check("cls_pl1", issue_payload[0], 101);
    squash = 1'b1;
    for (int k = 0; k < 3; k++) put(k, 1, 1, 2, 1, FU_ALU, 900 + k);
    #1 check("sq_iv", issue_valid, 0);
    nxt(); idle(); smp();
    check("sq_occ", occupancy, 0);
    check("sq_iv_after", issue_valid, 0);
    check("sq_stall", struct_stall, 0);

    // CDB wakeup, resident and at dispatch
    fu_ready = 4'hf;
    put(0, 7, 0, 9, 0, FU_ALU, 200);
    nxt(); idle();
    put(0, 9, 0, 20, 1, FU_LS, 201);
    bcast(0, 7); bcast(1, 9); bcast(2, 0);
    smp();
    check("wk_same_cyc", issue_valid, 0);
    nxt(); idle(); smp();
    check("wk_iv", issue_valid, 3'b011);
    check("wk_s1", issue_src1_pr[0], 7);
    check("wk_s2", issue_src2_pr[0], 9);
    check("wk_fu1", issue_fu[1], FU_LS);
    check("wk_pl1", issue_payload[1], 201);
    nxt(); smp();
    check("wk_occ", occupancy, 0);

    // Tag 0 is always ready
    put(0, 0, 0, 33, 1, FU_MULT, 300);
    nxt(); idle(); smp();
    check("z_iv", issue_valid, 3'b001);
    check("z_fu", issue_fu[0], FU_MULT);
    check("z_pl", issue_payload[0], 300);
    nxt(); smp();
    check("z_occ", occupancy, 0);

    // Contention: ALU ops land in entries 5, 2, 9 in that dispatch order
    fu_ready = 4'b1000;
    for (int e = 0; e < 10; e++) begin
      put(0, 6'(10 + e), 0, 6'(10 + e), 0, FU_BR, 400 + e);
      nxt();
    end
    idle();
    for (int j = 0; j < 3; j++) begin
      int t;
      t = (j == 0) ? 5 : (j == 1) ? 2 : 9;
      bcast(0, 6'(10 + t));
      nxt(); idle(); smp();
      check("blk_iv", issue_valid, 3'b001);
      check("blk_pl", issue_payload[0], 128'(400 + t));
      nxt();
      put(0, 40, 0, 41, 1, FU_ALU, 500 + j);
      nxt(); idle();
    end
    smp();
    check("ct_occ", occupancy, 10);
    bcast(0, 40); fu_ready = 4'b0001;
    nxt(); idle();
    for (int j = 0; j < 3; j++) begin
      smp();
      check("ct_iv", issue_valid, 3'b001);
      check("ct_order", issue_payload[0], 128'(exp_ord[j]));
      nxt();
    end
    smp();
    check("ct_occ_end", occupancy, 7);

    // Squashed entries never issue later
    squash = 1'b1;
    nxt(); idle();
    fu_ready = 4'hf;
    bcast(0, 10); bcast(1, 11); bcast(2, 13);
    nxt(); idle(); smp();
    check("post_sq_iv", issue_valid, 0);
    check("post_sq_occ", occupancy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
